// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-PC state encoding used by the
// branch-resolution / fetch-PC stage.
package rv32i_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/branch_taken_decode.sv
// Combinational taken/not-taken decode for conditional branches and jumps.
// Validity and pipeline-state gating are applied by the caller.
module branch_taken_decode
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       breq_i,
    input  logic       brlt_i,
    output logic       taken_o,
    output logic       is_branch_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        taken_o     = 1'b0;
        is_branch_o = 1'b0;
        case (opcode_i)
            OPCODE_BRANCH: begin
                is_branch_o = 1'b1;
                case (funct3_i)
                    F3_BEQ:  taken_o = breq_i;
                    F3_BNE:  taken_o = !breq_i;
                    F3_BLT:  taken_o = brlt_i;
                    F3_BGE:  taken_o = !brlt_i;
                    F3_BLTU: taken_o = brlt_i;
                    F3_BGEU: taken_o = !brlt_i;
                    default: taken_o = 1'b0;
                endcase
            end
            OPCODE_JAL:  taken_o = 1'b1;
            OPCODE_JALR: taken_o = 1'b1;
            default: begin
                taken_o     = 1'b0;
                is_branch_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC register and EX-stage branch resolution: redirect/flush, the
// misaligned-target halt, and conditional-branch statistics.
module pc_redirect_ctrl
    import rv32i_pkg::*;
#(
    parameter int                 DWIDTH   = 32,
    parameter int                 AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  BASEADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic [6:0]        ex_opcode_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [AWIDTH-1:0] ex_pc_i,
    input  logic [DWIDTH-1:0] ex_imm_i,
    input  logic [DWIDTH-1:0] ex_rs1_i,
    input  logic              breq_i,
    input  logic              brlt_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [AWIDTH-1:0] target_o,
    output logic              error_o,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       taken_cnt_o
);

    localparam logic [AWIDTH-1:0] PC_STEP   = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] JALR_MASK = ~AWIDTH'(1);

    pc_state_e         state_q;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              fetch_valid_q;
    logic              error_q;
    logic [31:0]       branch_cnt_q, branch_cnt_d;
    logic [31:0]       taken_cnt_q, taken_cnt_d;

    logic              dec_taken;
    logic              dec_is_branch;
    logic              resolve_en;
    logic              taken;
    logic              misaligned;
    logic [AWIDTH-1:0] pc_rel_target;
    logic [AWIDTH-1:0] jalr_sum;
    logic [AWIDTH-1:0] target;

    branch_taken_decode u_decode (
        .opcode_i    (ex_opcode_i),
        .funct3_i    (ex_funct3_i),
        .breq_i      (breq_i),
        .brlt_i      (brlt_i),
        .taken_o     (dec_taken),
        .is_branch_o (dec_is_branch)
    );

    // Decisions are only made for real instructions while running.
    assign resolve_en    = ex_valid_i && (state_q == RUN);
    assign taken         = resolve_en && dec_taken;

    assign pc_rel_target = ex_pc_i + ex_imm_i[AWIDTH-1:0];
    assign jalr_sum      = ex_rs1_i[AWIDTH-1:0] + ex_imm_i[AWIDTH-1:0];
    assign target        = (ex_opcode_i == OPCODE_JALR) ? (jalr_sum & JALR_MASK)
                                                        : pc_rel_target;
    assign misaligned    = taken && (target[1:0] != 2'b00);

    assign redirect_o    = taken;
    assign flush_o       = taken;
    assign target_o      = target;

    // A misaligned redirect still flushes but must not be fetched from.
    always_comb begin
        pc_d = pc_q;
        if (taken) begin
            if (!misaligned) begin
                pc_d = target;
            end
        end else if (!stall_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (resolve_en && dec_is_branch) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (dec_taken) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q       <= INIT;
            pc_q          <= BASEADDR;
            fetch_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q       <= RUN;
                    pc_q          <= BASEADDR;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    pc_q <= pc_d;
                    if (misaligned) begin
                        state_q       <= HALT;
                        fetch_valid_q <= 1'b0;
                        error_q       <= 1'b1;
                    end
                end
                HALT: begin
                    fetch_valid_q <= 1'b0;
                    error_q       <= 1'b1;
                end
                default: begin
                    state_q       <= INIT;
                    pc_q          <= BASEADDR;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign error_o       = error_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: inputs change on the falling edge,
// same-cycle outputs are checked 1ns later, registered ones a cycle later.
module tb_pc_redirect_ctrl;
    import rv32i_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        ex_valid_i;
    logic [6:0]  ex_opcode_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_imm_i;
    logic [31:0] ex_rs1_i;
    logic        breq_i;
    logic        brlt_i;
    logic [31:0] pc_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] target_o;
    logic        error_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] taken_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_redirect_ctrl #(
        .DWIDTH   (32),
        .AWIDTH   (32),
        .BASEADDR (BASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .ex_valid_i    (ex_valid_i),
        .ex_opcode_i   (ex_opcode_i),
        .ex_funct3_i   (ex_funct3_i),
        .ex_pc_i       (ex_pc_i),
        .ex_imm_i      (ex_imm_i),
        .ex_rs1_i      (ex_rs1_i),
        .breq_i        (breq_i),
        .brlt_i        (brlt_i),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .target_o      (target_o),
        .error_o       (error_o),
        .branch_cnt_o  (branch_cnt_o),
        .taken_cnt_o   (taken_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic eq, input logic lt);
        ex_valid_i  = v;
        ex_opcode_i = op;
        ex_funct3_i = f3;
        ex_pc_i     = pc;
        ex_imm_i    = imm;
        ex_rs1_i    = rs1;
        breq_i      = eq;
        brlt_i      = lt;
    endtask

    task automatic idle();
        set_ex(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc,
                               input logic fv, input logic err,
                               input logic [31:0] bc, input logic [31:0] tc);
        check({tag, "_pc"},    pc_o,                  pc);
        check({tag, "_fv"},    32'(fetch_valid_o),    32'(fv));
        check({tag, "_err"},   32'(error_o),          32'(err));
        check({tag, "_bcnt"},  branch_cnt_o,          bc);
        check({tag, "_tcnt"},  taken_cnt_o,           tc);
    endtask

    task automatic check_redirect(input string tag, input logic taken,
                                  input logic [31:0] tgt, input logic chk_tgt);
        check({tag, "_redirect"}, 32'(redirect_o), 32'(taken));
        check({tag, "_flush"},    32'(flush_o),    32'(taken));
        if (chk_tgt) check({tag, "_target"}, target_o, tgt);
    endtask

    initial begin
        rst_n   = 1'b0;
        stall_i = 1'b0;
        idle();

        // Reset values
        repeat (2) @(negedge clk);
        check_state("reset", BASE, 1'b0, 1'b0, 32'd0, 32'd0);
        check_redirect("reset", 1'b0, 32'd0, 1'b0);

        // INIT cycle, then sequential fetch
        rst_n = 1'b1;
        #1;
        check_state("init", BASE, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_state("run0", BASE, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_state("run1", BASE + 32'h4, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_state("run2", BASE + 32'h8, 1'b1, 1'b0, 32'd0, 32'd0);

        // Two stalled cycles hold the PC
        stall_i = 1'b1;
        @(negedge clk);
        check("stall1_pc", pc_o, BASE + 32'h8);
        @(negedge clk);
        check("stall2_pc", pc_o, BASE + 32'h8);
        stall_i = 1'b0;

        // Taken BEQ back to BASE
        set_ex(1'b1, OPCODE_BRANCH, F3_BEQ, 32'h0100_0010, 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0);
        #1;
        check_redirect("beq", 1'b1, BASE, 1'b1);
        @(negedge clk);
        idle();
        check_state("beq_next", BASE, 1'b1, 1'b0, 32'd1, 32'd1);

        // Not-taken BNE
        set_ex(1'b1, OPCODE_BRANCH, F3_BNE, 32'h0100_0020, 32'h8, 32'd0, 1'b1, 1'b0);
        #1;
        check_redirect("bne", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_state("bne_next", BASE + 32'h4, 1'b1, 1'b0, 32'd2, 32'd1);

        // Bubble: BNE with breq=0 would be taken, but ex_valid is low
        set_ex(1'b0, OPCODE_BRANCH, F3_BNE, 32'h0100_0020, 32'h8, 32'd0, 1'b0, 1'b0);
        #1;
        check_redirect("bubble", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_state("bubble_next", BASE + 32'h8, 1'b1, 1'b0, 32'd2, 32'd1);

        // JALR clears bit 0 and is not counted
        set_ex(1'b1, OPCODE_JALR, 3'b000, 32'h0100_0008, 32'h3, 32'h0100_0101, 1'b0, 1'b0);
        #1;
        check_redirect("jalr", 1'b1, 32'h0100_0104, 1'b1);
        @(negedge clk);
        check_state("jalr_next", 32'h0100_0104, 1'b1, 1'b0, 32'd2, 32'd1);

        // BLTU taken on brlt
        set_ex(1'b1, OPCODE_BRANCH, F3_BLTU, 32'h0100_0104, 32'h40, 32'd0, 1'b0, 1'b1);
        #1;
        check_redirect("bltu", 1'b1, 32'h0100_0144, 1'b1);
        @(negedge clk);
        check_state("bltu_next", 32'h0100_0144, 1'b1, 1'b0, 32'd3, 32'd2);

        // BGE not taken when brlt is set
        set_ex(1'b1, OPCODE_BRANCH, F3_BGE, 32'h0100_0144, 32'h40, 32'd0, 1'b0, 1'b1);
        #1;
        check_redirect("bge", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_state("bge_next", 32'h0100_0148, 1'b1, 1'b0, 32'd4, 32'd2);

        // funct3 010 never taken, still counted as a branch
        set_ex(1'b1, OPCODE_BRANCH, 3'b010, 32'h0100_0148, 32'h40, 32'd0, 1'b1, 1'b1);
        #1;
        check_redirect("f3_010", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_state("f3_010_next", 32'h0100_014C, 1'b1, 1'b0, 32'd5, 32'd2);

        // Target addition wraps at 2^32
        set_ex(1'b1, OPCODE_BRANCH, F3_BEQ, 32'hFFFF_FFF0, 32'h20, 32'd0, 1'b1, 1'b0);
        #1;
        check_redirect("wrap", 1'b1, 32'h0000_0010, 1'b1);
        @(negedge clk);
        check_state("wrap_next", 32'h0000_0010, 1'b1, 1'b0, 32'd6, 32'd3);

        // Redirect beats stall
        stall_i = 1'b1;
        set_ex(1'b1, OPCODE_JAL, 3'b000, 32'h0100_0100, 32'h100, 32'd0, 1'b0, 1'b0);
        #1;
        check_redirect("jal_stall", 1'b1, 32'h0100_0200, 1'b1);
        @(negedge clk);
        stall_i = 1'b0;
        check_state("jal_stall_next", 32'h0100_0200, 1'b1, 1'b0, 32'd6, 32'd3);

        // Misaligned JAL target: flush, then HALT with PC frozen
        set_ex(1'b1, OPCODE_JAL, 3'b000, 32'h0100_0000, 32'h2, 32'd0, 1'b0, 1'b0);
        #1;
        check_redirect("misalign", 1'b1, 32'h0100_0002, 1'b1);
        @(negedge clk);
        check_state("halt", 32'h0100_0200, 1'b0, 1'b1, 32'd6, 32'd3);

        // EX inputs ignored while halted
        set_ex(1'b1, OPCODE_BRANCH, F3_BEQ, 32'h0100_0010, 32'h10, 32'd0, 1'b1, 1'b0);
        #1;
        check_redirect("halt_ex", 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_state("halt_hold", 32'h0100_0200, 1'b0, 1'b1, 32'd6, 32'd3);
        idle();

        // Asynchronous reset from HALT, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", BASE, 1'b0, 1'b0, 32'd0, 32'd0);
        check_redirect("async_rst", 1'b0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
